// File: rtl/ibus_axi_rd_bridge.sv
`default_nettype none
// ============================================================================
//  Module   : ibus_axi_rd_bridge
//  Purpose  : Converts the instruction-fetch SRAM-like request/response
//             handshake into single-beat AXI3 read transactions. It allows one
//             outstanding transaction. The returned word is held for exactly
//             one cycle, with addr_ok and data_ok asserted together.
//  Ports    : clk, rst                  - clock, asynchronous active-high reset
//             if_addr/if_ben/if_wr      - fetch request (read when ben==4'hF)
//             flush                     - drop the in-flight fetch result
//             if_addr_ok/if_data_ok     - stall release / data valid pulse
//             if_rdata, bus_err         - fetched word, error pulse
//             ar*, r*                   - AXI3 read address / read data channels
//  Revision : 1.0 - initial release
// ============================================================================
module ibus_axi_rd_bridge #(
    parameter logic [3:0]  ARID_VAL    = 4'h0,
    parameter logic [31:0] RESET_RDATA = 32'h0
) (
    input  logic        clk,
    input  logic        rst,
    // fetch side
    input  logic [31:0] if_addr,
    input  logic [3:0]  if_ben,
    input  logic        if_wr,
    input  logic        flush,
    output logic        if_addr_ok,
    output logic        if_data_ok,
    output logic [31:0] if_rdata,
    output logic        bus_err,
    // AXI read address channel
    output logic [3:0]  arid,
    output logic [31:0] araddr,
    output logic [3:0]  arlen,
    output logic [2:0]  arsize,
    output logic [1:0]  arburst,
    output logic [1:0]  arlock,
    output logic [3:0]  arcache,
    output logic [2:0]  arprot,
    output logic        arvalid,
    input  logic        arready,
    // AXI read data channel
    input  logic [3:0]  rid,
    input  logic [31:0] rdata,
    input  logic [1:0]  rresp,
    input  logic        rlast,
    input  logic        rvalid,
    output logic        rready
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_AR   = 2'd1;
    localparam logic [1:0] S_R    = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    logic [1:0]  r_state;
    logic [31:0] r_araddr;
    logic [31:0] r_rdata;
    logic        r_err;
    logic        r_drop;

    logic        w_req;
    logic        w_beat_ok;
    logic        w_unused_rlast;

    // Single-beat bursts make rlast redundant.
    assign w_unused_rlast = rlast;

    assign w_req     = (if_ben == 4'b1111) && !if_wr;
    assign w_beat_ok = rvalid && (rid == ARID_VAL);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= S_IDLE;
            r_araddr <= 32'h0;
            r_rdata  <= 32'h0;
            r_err    <= 1'b0;
            r_drop   <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_req) begin
                        r_araddr <= if_addr;
                        r_state  <= S_AR;
                    end
                end
                S_AR: begin
                    // arvalid must stay up until arready, so a flush here
                    // only marks the result for discard.
                    if (flush) begin
                        r_drop <= 1'b1;
                    end
                    if (arready) begin
                        r_state <= S_R;
                    end
                end
                S_R: begin
                    if (w_beat_ok) begin
                        r_rdata <= rdata;
                        r_err   <= (rresp != 2'b00);
                        // A flush coinciding with the beat also discards it.
                        if (r_drop || flush) begin
                            r_drop  <= 1'b0;
                            r_state <= S_IDLE;
                        end else begin
                            r_state <= S_DONE;
                        end
                    end else if (flush) begin
                        r_drop <= 1'b1;
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    // Outputs decode directly from state so an asynchronous reset clears
    // them in the same cycle it is asserted.
    assign arvalid    = (r_state == S_AR);
    assign rready     = (r_state == S_R);
    assign if_addr_ok = (r_state == S_DONE);
    assign if_data_ok = (r_state == S_DONE);
    assign if_rdata   = (r_state == S_DONE) ? r_rdata : RESET_RDATA;
    assign bus_err    = (r_state == S_DONE) && r_err;

    assign araddr  = r_araddr;
    assign arid    = ARID_VAL;
    assign arlen   = 4'h0;
    assign arsize  = 3'b010;
    assign arburst = 2'b01;
    assign arlock  = 2'b00;
    assign arcache = 4'h0;
    assign arprot  = 3'h0;

endmodule
`default_nettype wire

// File: tb/tb_ibus_axi_rd_bridge.sv
`default_nettype none
// ============================================================================
//  Module   : tb_ibus_axi_rd_bridge
//  Purpose  : Self-checking bench for ibus_axi_rd_bridge. A scripted AXI
//             slave follows a per-fetch schedule (AR wait, R wait, foreign
//             beats, flush cycle). The expected cycle-by-cycle channel
//             activity and delivery are derived from the latency rules.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_ibus_axi_rd_bridge;

    localparam logic [3:0]  C_ARID  = 4'h0;
    localparam logic [31:0] C_RDATA = 32'h0;

    logic        clk;
    logic        rst;
    logic [31:0] if_addr;
    logic [3:0]  if_ben;
    logic        if_wr;
    logic        flush;
    logic        if_addr_ok;
    logic        if_data_ok;
    logic [31:0] if_rdata;
    logic        bus_err;
    logic [3:0]  arid;
    logic [31:0] araddr;
    logic [3:0]  arlen;
    logic [2:0]  arsize;
    logic [1:0]  arburst;
    logic [1:0]  arlock;
    logic [3:0]  arcache;
    logic [2:0]  arprot;
    logic        arvalid;
    logic        arready;
    logic [3:0]  rid;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rlast;
    logic        rvalid;
    logic        rready;

    int n_chk = 0;
    int n_err = 0;

    ibus_axi_rd_bridge #(
        .ARID_VAL    (C_ARID),
        .RESET_RDATA (C_RDATA)
    ) u_dut (
        .clk        (clk),
        .rst        (rst),
        .if_addr    (if_addr),
        .if_ben     (if_ben),
        .if_wr      (if_wr),
        .flush      (flush),
        .if_addr_ok (if_addr_ok),
        .if_data_ok (if_data_ok),
        .if_rdata   (if_rdata),
        .bus_err    (bus_err),
        .arid       (arid),
        .araddr     (araddr),
        .arlen      (arlen),
        .arsize     (arsize),
        .arburst    (arburst),
        .arlock     (arlock),
        .arcache    (arcache),
        .arprot     (arprot),
        .arvalid    (arvalid),
        .arready    (arready),
        .rid        (rid),
        .rdata      (rdata),
        .rresp      (rresp),
        .rlast      (rlast),
        .rvalid     (rvalid),
        .rready     (rready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One fetch, cycle 0 = request presented in IDLE.
    // arw: arready wait cycles, rw: rvalid wait cycles, nf: foreign-ID beats
    // ahead of the good beat, fl_t: cycle at which flush pulses (-1 = none),
    // fid: ID carried by the foreign beats.
    task automatic fetch(input logic [31:0] addr, input int arw, input int rw,
                         input int nf, input logic [1:0] resp,
                         input logic [31:0] data, input int fl_t,
                         input logic [3:0] fid);
        int  exp_t;
        int  r_first;
        bit  dropped;
        exp_t   = 3 + arw + rw + nf;
        r_first = 2 + arw + rw;
        dropped = (fl_t >= 1) && (fl_t <= exp_t - 1);
        for (int t = 0; t <= exp_t + 2; t++) begin
            // observe state reached by previous edges
            chk_eq("arvalid", 64'(arvalid), 64'((t >= 1) && (t <= 1 + arw)));
            chk_eq("rready", 64'(rready), 64'((t >= 2 + arw) && (t <= exp_t - 1)));
            if (arvalid) begin
                chk_eq("araddr", 64'(araddr), 64'(addr));
            end
            if ((t == exp_t) && !dropped) begin
                chk_eq("deliver", {29'h0, if_addr_ok, if_data_ok, bus_err, if_rdata},
                       {29'h0, 1'b1, 1'b1, (resp != 2'b00), data});
            end else begin
                chk_eq("quiet", {29'h0, if_addr_ok, if_data_ok, bus_err, if_rdata},
                       {29'h0, 3'b000, C_RDATA});
            end
            // drive this cycle
            if_ben  = (t == 0) ? 4'hF : 4'h0;
            if_addr = (t == 0) ? addr : $urandom;
            flush   = (t == fl_t);
            arready = (t == 1 + arw);
            rvalid  = (t >= r_first) && (t <= exp_t - 1);
            rlast   = 1'b1;
            if (rvalid && (t - r_first < nf)) begin
                rid   = fid;
                rdata = $urandom;
                rresp = 2'($urandom);
            end else begin
                rid   = C_ARID;
                rdata = data;
                rresp = resp;
            end
            tick();
        end
        arready = 1'b0;
        rvalid  = 1'b0;
        flush   = 1'b0;
    endtask

    initial begin
        logic [31:0] a;
        logic [31:0] d;
        int          arw, rw, nf, fl, exp_t, sel;
        rst = 1'b1; if_addr = 32'h0; if_ben = 4'h0; if_wr = 1'b0; flush = 1'b0;
        arready = 1'b0; rid = 4'h0; rdata = 32'h0; rresp = 2'b00; rlast = 1'b0;
        rvalid = 1'b0;
        repeat (3) tick();
        rst = 1'b0;
        tick();

        // reset state and constant AR attributes
        chk_eq("reset_outs", {26'h0, arvalid, rready, if_addr_ok, if_data_ok, bus_err, if_rdata},
               {26'h0, 5'b00000, C_RDATA});
        chk_eq("reset_araddr", 64'(araddr), 64'h0);
        chk_eq("ar_attr", {arid, arlen, arsize, arburst, arlock, arcache, arprot},
               {C_ARID, 4'h0, 3'b010, 2'b01, 2'b00, 4'h0, 3'h0});

        // zero-wait read
        fetch(32'h1FC0_0000, 0, 0, 0, 2'b00, 32'h3C08_BFAF, -1, 4'h5);
        // backpressure: data_ok at cycle 10
        fetch(32'h1FC0_0004, 4, 3, 0, 2'b00, 32'h2408_0001, -1, 4'h5);
        // flush while in R, then a normal fetch
        fetch(32'h1FC0_0008, 0, 1, 0, 2'b00, 32'h1111_2222, 2, 4'h5);
        fetch(32'h1FC0_000C, 0, 0, 0, 2'b00, 32'h3333_4444, -1, 4'h5);
        // foreign ID beat first, then error response
        fetch(32'h1FC0_0010, 0, 0, 1, 2'b10, 32'hDEAD_BEEF, -1, 4'h5);

        // non-requests
        if_ben = 4'h0; if_wr = 1'b0; if_addr = 32'h1FC0_0100;
        for (int i = 0; i < 20; i++) begin
            tick();
            chk_eq("noreq_ben0", {62'h0, arvalid, if_addr_ok}, 64'h0);
        end
        if_ben = 4'hF; if_wr = 1'b1;
        for (int i = 0; i < 20; i++) begin
            tick();
            chk_eq("noreq_wr", {62'h0, arvalid, if_addr_ok}, 64'h0);
        end
        if_ben = 4'h0; if_wr = 1'b0;
        tick();

        // asynchronous reset while in AR
        if_addr = 32'h1FC0_0200; if_ben = 4'hF;
        tick();
        if_ben = 4'h0;
        chk_eq("rst_pre_ar", 64'(arvalid), 64'h1);
        #2 rst = 1'b1;
        #1;
        chk_eq("rst_async", {26'h0, arvalid, rready, if_addr_ok, if_data_ok, bus_err, if_rdata},
               {26'h0, 5'b00000, C_RDATA});
        chk_eq("rst_async_araddr", 64'(araddr), 64'h0);
        tick();
        rst = 1'b0;
        tick();
        fetch(32'h1FC0_0300, 1, 0, 0, 2'b00, 32'h0000_0013, -1, 4'h5);

        // randomized fetches
        for (int n = 0; n < 40; n++) begin
            a     = $urandom & 32'hFFFF_FFFC;
            d     = $urandom;
            arw   = int'($urandom_range(0, 3));
            rw    = int'($urandom_range(0, 3));
            nf    = int'($urandom_range(0, 2));
            exp_t = 3 + arw + rw + nf;
            sel   = int'($urandom_range(0, 4));
            case (sel)
                0:       fl = 0;
                1:       fl = exp_t;
                2, 3:    fl = int'($urandom_range(1, exp_t - 1));
                default: fl = -1;
            endcase
            fetch(a, arw, rw, nf, 2'($urandom), d, fl, C_ARID ^ 4'($urandom_range(1, 15)));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/ibus_axi_rd_bridge.md
Name: ibus_axi_rd_bridge

Overview:
- Downstream neighbour of the instruction fetch port. Converts its SRAM-like request/response handshake into single-beat AXI3 read transactions on the instruction bus.
- One outstanding transaction at a time.
- The returned word is held in a one-entry buffer and presented to fetch for exactly one cycle, with addr_ok and data_ok asserted together. This releases the fetch stall in the same cycle the instruction is valid.

Parameters:
- ARID_VAL, 4'h0, constant ID driven on arid; R beats with other IDs are drained and discarded.
- RESET_RDATA, 32'h0, value of if_rdata while no data is being delivered.

Ports:
- clk  input  1  system clock
- rst  input  1  asynchronous, active-high reset
- if_addr  input  32  physical fetch address (already segment-translated)
- if_ben  input  4  byte enables; 4'b1111 = read request, any other value = no request
- if_wr  input  1  write strobe; tied 0 by fetch; any request with if_wr=1 is ignored
- flush  input  1  pipeline flush; the in-flight fetch result must be dropped
- if_addr_ok  output  1  request accepted/completed (fetch stall release)
- if_data_ok  output  1  if_rdata valid this cycle
- if_rdata  output  32  fetched instruction word
- bus_err  output  1  one-cycle pulse with data_ok when rresp != 2'b00
- arid  output  4  = ARID_VAL
- araddr  output  32  latched request address
- arlen  output  4  = 0
- arsize  output  3  = 3'b010
- arburst  output  2  = 2'b01
- arlock  output  2  = 0
- arcache  output  4  = 0
- arprot  output  3  = 0
- arvalid  output  1  AR valid
- arready  input  1  AR ready
- rid  input  4  R ID
- rdata  input  32  R data
- rresp  input  2  R response
- rlast  input  1  R last
- rvalid  input  1  R valid
- rready  output  1  R ready

Behaviour:
Reset:
- state=IDLE; arvalid=0, rready=0, if_addr_ok=0, if_data_ok=0, bus_err=0.
- if_rdata=RESET_RDATA; araddr register=0; drop flag=0.
- Async assertion mid-transaction forces IDLE immediately. The slave shares rst, so the abandoned transaction is acceptable.

State machine (IDLE, AR, R, DONE):
- IDLE: if if_ben==4'b1111 and if_wr==0, latch if_addr into araddr and go to AR. Otherwise stay.
- AR: arvalid=1 with araddr held stable. When arvalid&&arready, go to R. arvalid is never deasserted before arready (AXI rule), even on flush.
- R: rready=1. When rvalid with rid==ARID_VAL:
  - capture rdata and rresp;
  - go to DONE if drop==0, else go to IDLE and clear drop.
  - Beats with rid!=ARID_VAL are accepted and discarded; stay in R.
- DONE: for exactly one cycle, if_addr_ok=1, if_data_ok=1, if_rdata=captured word, bus_err=(captured rresp!=0). Then go to IDLE.

Outputs outside DONE:
- if_addr_ok=0, if_data_ok=0, if_rdata=RESET_RDATA, bus_err=0.

Flush handling:
- flush asserted in AR or R sets drop=1. The AXI transaction still completes, but no data_ok/addr_ok is produced.
- flush in DONE has no effect (the result is delivered).
- flush in IDLE has no effect.

Latency:
- Minimum request-to-data_ok is 3 cycles: request seen in IDLE at cycle 0, AR handshake at cycle 1 with arready=1, R beat at cycle 2 with rvalid=1, DONE at cycle 3.
- Every arready or rvalid wait cycle adds 1.

Other rules:
- A new request is sampled only in IDLE. The cycle after DONE is always IDLE, so back-to-back fetches are separated by at least one IDLE cycle.
- if_addr changes after latching are ignored until the next IDLE.
- rlast is ignored (arlen=0 guarantees a single beat).

Test Plan:
- Zero-wait read: rst released; if_addr=32'h1FC0_0000, if_ben=4'hF; arready=1; rvalid at first rready cycle with rdata=32'h3C08_BFAF, rresp=0. Expect:
  - araddr=32'h1FC0_0000 and arvalid high at cycle 1;
  - if_data_ok=if_addr_ok=1 with if_rdata=32'h3C08_BFAF at cycle 3 only;
  - arlen=0, arsize=2, arburst=1.
- Backpressure: arready held low 4 cycles, then rvalid delayed 3 cycles. Expect:
  - arvalid and araddr stable throughout;
  - data_ok at cycle 3+4+3=10;
  - if_addr change during the wait does not alter araddr.
- Flush: flush pulsed while in R. Expect the beat to be consumed (rready=1), no data_ok, state IDLE. The next request completes normally with its own data.
- Error and ID filtering: a beat with rid=4'h5 arrives first, then rid=ARID_VAL with rresp=2'b10, rdata=32'hDEAD_BEEF. Expect the first beat discarded, and data_ok with if_rdata=32'hDEAD_BEEF and bus_err=1 for one cycle.
- Non-request: if_ben=4'b0000, or if_wr=1 with if_ben=4'hF. Expect arvalid to stay 0 and no addr_ok for 20 cycles.
- Reset mid-flight: assert rst while in AR. Expect arvalid=0 and all outputs at reset values in the same cycle (asynchronous). After release, a fresh request starts from IDLE.
